dspb_serum_qsys_nios2_qsys_0_oci_dct_packer: RTL and testbench

Producer end of the OCI debug-trace (DCT) buffer interface of the Nios II core in dspb_serum_qsys. Accepts 2-bit trace atoms one per cycle and packs up to 15 of them into a 30-bit buffer word with a 4-bit atom count. Emits each word through a single-entry valid/ready output register, flushes partial words on idle timeout or end of test, and drives the test_ending / test_has_ended pair consumed by the OCI test bench.

---
 rtl/dspb_serum_qsys_nios2_qsys_0_oci_dct_packer.sv | 120 ++++++++++++
 tb/tb_dspb_serum_qsys_nios2_qsys_0_oci_dct_packer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dspb_serum_qsys_nios2_qsys_0_oci_dct_packer.sv
// OCI debug-trace packer: packs 2-bit atoms into 30-bit words (up to 15 atoms) behind a
// single-entry valid/ready output register, with idle-timeout and end-of-test flushing.
module dspb_serum_qsys_nios2_qsys_0_oci_dct_packer #(
   parameter int unsigned FlushTimeout = 64
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        atom_valid_i,
   input  logic [1:0]  atom_i,
   output logic        atom_ready_o,
   input  logic        end_req_i,
   output logic [29:0] dct_buffer_o,
   output logic [3:0]  dct_count_o,
   output logic        dct_valid_o,
   input  logic        dct_ready_i,
   output logic        test_ending_o,
   output logic        test_has_ended_o
);

   localparam int unsigned    IdleW   = $clog2(FlushTimeout);
   localparam logic [IdleW-1:0] IdleMax = IdleW'(FlushTimeout - 1);

   typedef enum logic [1:0] {StRun, StEnding, StEnded} state_e;

   state_e            state_q, state_d;
   logic [29:0]       acc_q, acc_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [IdleW-1:0]  idle_q, idle_d;
   logic [29:0]       buf_q, buf_d;
   logic [3:0]        count_q, count_d;
   logic              valid_q, valid_d;

   logic out_free;
   logic accept;
   logic full_load;
   logic flush;

   always_comb begin
      out_free     = ~valid_q | dct_ready_i;
      atom_ready_o = ~reset_i & (state_q == StRun) & ((cnt_q != 4'd14) | out_free);
      accept       = atom_valid_i & atom_ready_o;
      full_load    = accept & (cnt_q == 4'd14);
      // A partial word leaves on idle timeout in RUN, or as soon as possible in ENDING.
      flush        = ~accept & (cnt_q != 4'd0) & out_free &
                     (((state_q == StRun) & (idle_q == IdleMax)) | (state_q == StEnding));
   end

   always_comb begin
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      idle_d  = idle_q;
      buf_d   = buf_q;
      count_d = count_q;
      valid_d = valid_q;
      state_d = state_q;

      if (accept) begin
         idle_d = '0;
         if (full_load) begin
            acc_d = '0;
            cnt_d = 4'd0;
         end else begin
            acc_d[{cnt_q, 1'b0} +: 2] = atom_i;
            cnt_d                      = cnt_q + 4'd1;
         end
      end else if (flush) begin
         acc_d  = '0;
         cnt_d  = 4'd0;
         idle_d = '0;
      end else if ((state_q == StRun) && (cnt_q != 4'd0) && (idle_q != IdleMax)) begin
         idle_d = idle_q + 1'b1;
      end

      if (full_load) begin
         buf_d   = {atom_i, acc_q[27:0]};
         count_d = 4'd15;
         valid_d = 1'b1;
      end else if (flush) begin
         buf_d   = acc_q;
         count_d = cnt_q;
         valid_d = 1'b1;
      end else if (dct_ready_i) begin
         valid_d = 1'b0;
      end

      unique case (state_q)
         StRun:    if (end_req_i) state_d = StEnding;
         StEnding: if ((cnt_q == 4'd0) && !valid_q) state_d = StEnded;
         StEnded:  state_d = StEnded;
         default:  state_d = StRun;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= StRun;
         acc_q   <= '0;
         cnt_q   <= 4'd0;
         idle_q  <= '0;
         buf_q   <= '0;
         count_q <= 4'd0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         idle_q  <= idle_d;
         buf_q   <= buf_d;
         count_q <= count_d;
         valid_q <= valid_d;
      end
   end

   assign dct_buffer_o     = buf_q;
   assign dct_count_o      = count_q;
   assign dct_valid_o      = valid_q;
   assign test_ending_o    = (state_q != StRun);
   assign test_has_ended_o = (state_q == StEnded);

endmodule

// File: tb/tb_dspb_serum_qsys_nios2_qsys_0_oci_dct_packer.sv
// Scoreboard bench for the DCT packer: expected words are queued as atoms are accepted and
// compared at each output handshake.
module tb_dspb_serum_qsys_nios2_qsys_0_oci_dct_packer;

   localparam int unsigned FlushTimeout = 8;

   logic        clk;
   logic        reset;
   logic        atom_valid;
   logic [1:0]  atom;
   logic        atom_ready;
   logic        end_req;
   logic [29:0] dct_buffer;
   logic [3:0]  dct_count;
   logic        dct_valid;
   logic        dct_ready;
   logic        test_ending;
   logic        test_has_ended;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [33:0] sb_q[$];
   logic [33:0] sb_exp;
   logic [29:0] m_acc;
   int          m_cnt;
   int          stalls;

   dspb_serum_qsys_nios2_qsys_0_oci_dct_packer #(
      .FlushTimeout(FlushTimeout)
   ) u_dut (
      .clk_i           (clk),
      .reset_i         (reset),
      .atom_valid_i    (atom_valid),
      .atom_i          (atom),
      .atom_ready_o    (atom_ready),
      .end_req_i       (end_req),
      .dct_buffer_o    (dct_buffer),
      .dct_count_o     (dct_count),
      .dct_valid_o     (dct_valid),
      .dct_ready_i     (dct_ready),
      .test_ending_o   (test_ending),
      .test_has_ended_o(test_has_ended)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Every output handshake must match the oldest expected word.
   always @(negedge clk) begin
      if (!reset && dct_valid && dct_ready) begin
         chk("word_cnt_nonzero", 64'(dct_count == 4'd0), 64'd0);
         if (sb_q.size() == 0) begin
            chk("sb_extra_word", 64'({dct_count, dct_buffer}), 64'd0);
         end else begin
            sb_exp = sb_q.pop_front();
            chk("sb_word", 64'({dct_count, dct_buffer}), 64'(sb_exp));
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic model_pack(input logic [1:0] a);
      m_acc[2*m_cnt +: 2] = a;
      m_cnt++;
      if (m_cnt == 15) begin
         sb_q.push_back({4'd15, m_acc});
         m_acc = '0;
         m_cnt = 0;
      end
   endtask

   task automatic model_flush();
      if (m_cnt > 0) sb_q.push_back({4'(m_cnt), m_acc});
      m_acc = '0;
      m_cnt = 0;
   endtask

   task automatic send_atom(input logic [1:0] a);
      int waits = 0;
      atom_valid = 1'b1;
      atom       = a;
      while (1) begin
         @(negedge clk);
         if (atom_ready) break;
         waits++;
         if (waits > 50) break;
      end
      if (waits > 50) chk("send_timeout", 64'(atom_ready), 64'd1);
      else model_pack(a);
      stalls += waits;
      cyc();
   endtask

   task automatic do_reset();
      reset      = 1'b1;
      atom_valid = 1'b0;
      end_req    = 1'b0;
      cyc();
      cyc();
      @(negedge clk);
      chk("rst_atom_ready", 64'(atom_ready), 64'd0);
      chk("rst_valid", 64'(dct_valid), 64'd0);
      chk("rst_count", 64'(dct_count), 64'd0);
      chk("rst_buffer", 64'(dct_buffer), 64'd0);
      chk("rst_ending", 64'(test_ending), 64'd0);
      chk("rst_ended", 64'(test_has_ended), 64'd0);
      cyc();
      reset = 1'b0;
      sb_q.delete();
      m_acc = '0;
      m_cnt = 0;
      @(negedge clk);
      chk("rst_ready_first", 64'(atom_ready), 64'd1);
      cyc();
   endtask

   initial begin
      logic [1:0] a;
      int         lat;
      int         vcnt;
      atom       = 2'd0;
      atom_valid = 1'b0;
      end_req    = 1'b0;
      dct_ready  = 1'b1;
      reset      = 1'b1;
      m_acc      = '0;
      m_cnt      = 0;
      do_reset();

      // Full word at full rate.
      stalls = 0;
      for (int i = 0; i < 15; i++) send_atom(2'(i % 4));
      atom_valid = 1'b0;
      @(negedge clk);
      chk("t1_valid", 64'(dct_valid), 64'd1);
      chk("t1_buffer", 64'(dct_buffer), 64'h24E4_E4E4);
      chk("t1_count", 64'(dct_count), 64'd15);
      cyc();
      @(negedge clk);
      chk("t1_pulse", 64'(dct_valid), 64'd0);
      chk("t1_no_stall", 64'(stalls), 64'd0);
      cyc();

      // Back-pressure: hold the first word, fill the accumulator, then drain and reload.
      dct_ready = 1'b0;
      stalls    = 0;
      for (int i = 0; i < 29; i++) begin
         a = 2'($urandom_range(0, 3));
         send_atom(a);
      end
      chk("t2_no_stall", 64'(stalls), 64'd0);
      a = 2'd2;
      fork
         send_atom(a);
         begin
            @(negedge clk);
            chk("t2_ready_low", 64'(atom_ready), 64'd0);
            chk("t2_held", 64'(dct_valid), 64'd1);
            cyc();
            dct_ready = 1'b1;
         end
      join
      atom_valid = 1'b0;
      @(negedge clk);
      chk("t2_no_gap", 64'(dct_valid), 64'd1);
      chk("t2_count2", 64'(dct_count), 64'd15);
      repeat (3) cyc();

      // Idle-timeout flush of a partial word.
      send_atom(2'd3);
      send_atom(2'd2);
      send_atom(2'd1);
      atom_valid = 1'b0;
      model_flush();
      lat = 0;
      while (lat < 100) begin
         @(negedge clk);
         if (dct_valid) break;
         lat++;
      end
      chk("t3_latency", 64'(lat), 64'(FlushTimeout));
      chk("t3_buffer", 64'(dct_buffer), 64'h1B);
      chk("t3_count", 64'(dct_count), 64'd3);
      repeat (2) cyc();

      // End request with a partial word pending.
      for (int i = 0; i < 5; i++) send_atom(2'((i * 3 + 1) % 4));
      atom_valid = 1'b0;
      model_flush();
      end_req = 1'b1;
      cyc();
      end_req = 1'b0;
      @(negedge clk);
      chk("t4_ending", 64'(test_ending), 64'd1);
      chk("t4_not_ended", 64'(test_has_ended), 64'd0);
      chk("t4_ready_low", 64'(atom_ready), 64'd0);
      lat = 0;
      while (!dct_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      chk("t4_flush_latency", 64'(lat), 64'd1);
      chk("t4_count", 64'(dct_count), 64'd5);
      @(negedge clk);
      chk("t4_ended_early", 64'(test_has_ended), 64'd0);
      @(negedge clk);
      chk("t4_ended", 64'(test_has_ended), 64'd1);
      cyc();
      atom_valid = 1'b1;
      vcnt = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (atom_ready || dct_valid) vcnt++;
      end
      chk("t4_ignored", 64'(vcnt), 64'd0);
      chk("t4_still_ended", 64'(test_has_ended), 64'd1);
      atom_valid = 1'b0;
      cyc();

      // End request on the edge that accepts the 15th atom.
      do_reset();
      for (int i = 0; i < 14; i++) send_atom(2'(3 - (i % 4)));
      end_req = 1'b1;
      send_atom(2'd1);
      end_req    = 1'b0;
      atom_valid = 1'b0;
      @(negedge clk);
      chk("t5_valid", 64'(dct_valid), 64'd1);
      chk("t5_count", 64'(dct_count), 64'd15);
      chk("t5_ending", 64'(test_ending), 64'd1);
      @(negedge clk);
      chk("t5_ended_early", 64'(test_has_ended), 64'd0);
      @(negedge clk);
      chk("t5_ended", 64'(test_has_ended), 64'd1);
      repeat (5) @(negedge clk);
      chk("t5_sb_empty", 64'(sb_q.size()), 64'd0);

      // Reset with a held word and a 7-atom partial.
      do_reset();
      dct_ready = 1'b0;
      for (int i = 0; i < 22; i++) send_atom(2'(i % 3));
      atom_valid = 1'b0;
      @(negedge clk);
      chk("t6_held", 64'(dct_valid), 64'd1);
      cyc();
      reset = 1'b1;
      @(negedge clk);
      chk("t6_ready_in_reset", 64'(atom_ready), 64'd0);
      cyc();
      @(negedge clk);
      chk("t6_valid_cleared", 64'(dct_valid), 64'd0);
      chk("t6_count_cleared", 64'(dct_count), 64'd0);
      chk("t6_flags_cleared", 64'({test_ending, test_has_ended}), 64'd0);
      cyc();
      reset = 1'b0;
      sb_q.delete();
      m_acc     = '0;
      m_cnt     = 0;
      dct_ready = 1'b1;
      vcnt      = 0;
      for (int i = 0; i < 3 * FlushTimeout; i++) begin
         @(negedge clk);
         if (dct_valid) vcnt++;
      end
      chk("t6_no_flush", 64'(vcnt), 64'd0);

      chk("sb_drained", 64'(sb_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
